// File: rtl/ct_mmu_sysmap_pkg.sv
// Shared sysmap lookup constants and the attribute response record used by
// the MMU sysmap arbitration path.
package ct_mmu_sysmap_pkg;

  localparam int SYSMAP_PA_WIDTH  = 28;
  localparam int SYSMAP_FLG_WIDTH = 5;
  localparam int SYSMAP_HIT_WIDTH = 8;

  // Attributes the sysmap returns when no region matches.
  localparam logic [SYSMAP_FLG_WIDTH-1:0] SYSMAP_FLG_DFLT = 5'b10011;

  typedef struct packed {
    logic [SYSMAP_FLG_WIDTH-1:0] flg;
    logic [SYSMAP_HIT_WIDTH-1:0] hit;
  } sysmap_rsp_t;

endpackage

// File: rtl/ct_mmu_sysmap_arb_if.sv
// Request/response and sysmap-facing signals of the sysmap arbiter.
// The slave modport is the arbiter side; master is the requesters plus sysmap.
interface ct_mmu_sysmap_arb_if
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int PA_WIDTH  = SYSMAP_PA_WIDTH,
  parameter int FLG_WIDTH = SYSMAP_FLG_WIDTH,
  parameter int HIT_WIDTH = SYSMAP_HIT_WIDTH,
  parameter int ID_WIDTH  = $clog2(NREQ)
);

  logic [NREQ-1:0]          req_vld;
  logic [NREQ*PA_WIDTH-1:0] req_pa;
  logic [NREQ-1:0]          arb_gnt;
  logic                     resp_vld;
  logic [ID_WIDTH-1:0]      resp_id;
  logic [FLG_WIDTH-1:0]     resp_flg;
  logic [HIT_WIDTH-1:0]     resp_hit;
  logic                     resp_miss;
  logic [PA_WIDTH-1:0]      arb_sysmap_pa_y;
  logic [FLG_WIDTH-1:0]     sysmap_arb_flg_y;
  logic [HIT_WIDTH-1:0]     sysmap_arb_hit_y;
  logic                     mmu_sysmap_flush;
  logic                     arb_busy;

  modport slave (
    input  req_vld, req_pa, sysmap_arb_flg_y, sysmap_arb_hit_y, mmu_sysmap_flush,
    output arb_gnt, resp_vld, resp_id, resp_flg, resp_hit, resp_miss,
           arb_sysmap_pa_y, arb_busy
  );

  modport master (
    output req_vld, req_pa, sysmap_arb_flg_y, sysmap_arb_hit_y, mmu_sysmap_flush,
    input  arb_gnt, resp_vld, resp_id, resp_flg, resp_hit, resp_miss,
           arb_sysmap_pa_y, arb_busy
  );

endinterface

// File: rtl/ct_mmu_sysmap_rr_arb.sv
// Generic round-robin arbiter: one-hot grant scanning upward from the last
// winner, with the pointer advancing only when something is granted.
module ct_mmu_sysmap_rr_arb #(
  parameter int NREQ     = 3,
  parameter int ID_WIDTH = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic [ID_WIDTH-1:0] gnt_idx,
  output logic                gnt_vld
);

  logic [ID_WIDTH-1:0] rr_ptr;
  int                  idx;

  // Index wraps at NREQ rather than 2^ID_WIDTH so non-power-of-two counts work.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        if (!gnt_vld && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = ID_WIDTH'(idx);
          gnt_vld  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= ID_WIDTH'(NREQ - 1);
    end else if (gnt_vld) begin
      rr_ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/ct_mmu_sysmap_arb.sv
// Shares one combinational sysmap lookup between MMU requesters: round-robin
// grant, registered PA to sysmap, registered result, fixed 2-cycle latency.
module ct_mmu_sysmap_arb
  import ct_mmu_sysmap_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int PA_WIDTH  = SYSMAP_PA_WIDTH,
  parameter int FLG_WIDTH = SYSMAP_FLG_WIDTH,
  parameter int HIT_WIDTH = SYSMAP_HIT_WIDTH,
  parameter int ID_WIDTH  = $clog2(NREQ)
) (
  input logic                forever_cpuclk,
  input logic                cpurst,
  ct_mmu_sysmap_arb_if.slave bus
);

  logic [NREQ-1:0]      gnt;
  logic [ID_WIDTH-1:0]  gnt_idx;
  logic                 gnt_vld;
  logic                 arb_en;
  logic [PA_WIDTH-1:0]  gnt_pa;

  logic                 s1_vld;
  logic [ID_WIDTH-1:0]  s1_id;
  logic [PA_WIDTH-1:0]  s1_pa;

  logic                 s2_vld;
  logic [ID_WIDTH-1:0]  s2_id;
  logic [FLG_WIDTH-1:0] s2_flg;
  logic [HIT_WIDTH-1:0] s2_hit;

  // No new lookups start while the sysmap is being flushed or held in reset.
  assign arb_en = ~bus.mmu_sysmap_flush & ~cpurst;

  ct_mmu_sysmap_rr_arb #(
    .NREQ     (NREQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arb (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .en      (arb_en),
    .req     (bus.req_vld),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gnt_pa = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_pa = bus.req_pa[i*PA_WIDTH +: PA_WIDTH];
      end
    end
  end

  // Data registers load only behind a valid so idle cycles leave them quiet.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_pa  <= '0;
      s2_vld <= 1'b0;
      s2_id  <= '0;
      s2_flg <= '0;
      s2_hit <= '0;
    end else begin
      s1_vld <= gnt_vld & ~bus.mmu_sysmap_flush;
      if (gnt_vld) begin
        s1_id <= gnt_idx;
        s1_pa <= gnt_pa;
      end
      s2_vld <= s1_vld & ~bus.mmu_sysmap_flush;
      if (s1_vld) begin
        s2_id  <= s1_id;
        s2_flg <= bus.sysmap_arb_flg_y;
        s2_hit <= bus.sysmap_arb_hit_y;
      end
    end
  end

  assign bus.arb_gnt         = gnt;
  assign bus.arb_sysmap_pa_y = s1_pa;
  assign bus.resp_vld        = s2_vld & ~bus.mmu_sysmap_flush;
  assign bus.resp_id         = s2_id;
  assign bus.resp_flg        = s2_flg;
  assign bus.resp_hit        = s2_hit;
  assign bus.resp_miss       = (s2_hit == '0);
  assign bus.arb_busy        = s1_vld | s2_vld;

endmodule

// File: tb/tb_ct_mmu_sysmap_arb.sv
// Self-checking bench for ct_mmu_sysmap_arb: directed vector table, hand
// sequences for withdraw/reset, then random traffic against a lookup queue model.
module tb_ct_mmu_sysmap_arb;
  import ct_mmu_sysmap_pkg::*;

  localparam int NREQ = 3;
  localparam int PAW  = 28;

  localparam logic [27:0] PA_R1   = 28'h1000000;
  localparam logic [27:0] PA_R2   = 28'h2000000;
  localparam logic [27:0] PA_R3   = 28'h3000000;
  localparam logic [27:0] PA_A    = 28'h0001234;
  localparam logic [27:0] PA_MISS = 28'h8000000;

  typedef struct {
    logic [2:0]  req;
    logic [27:0] pa0, pa1, pa2;
    logic        flush;
    logic [2:0]  gnt;
    logic        rv;
    logic [1:0]  rid;
    logic [4:0]  rflg;
    logic [7:0]  rhit;
    logic        chk_pa;
    logic [27:0] pa_y;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [27:0] pa;
  } lookup_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ct_mmu_sysmap_arb_if #(.NREQ(NREQ), .PA_WIDTH(PAW), .FLG_WIDTH(5), .HIT_WIDTH(8)) bus ();

  ct_mmu_sysmap_arb #(.NREQ(NREQ), .PA_WIDTH(PAW), .FLG_WIDTH(5), .HIT_WIDTH(8)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  // Stand-in sysmap: PPN[27]=1 misses, otherwise PPN[26:24] selects the region.
  function automatic sysmap_rsp_t sysmap_lookup(input logic [27:0] pa);
    sysmap_rsp_t r;
    r.hit = '0;
    if (pa[27]) begin
      r.flg = SYSMAP_FLG_DFLT;
    end else begin
      r.flg = {2'b01, pa[26:24]};
      r.hit[pa[26:24]] = 1'b1;
    end
    return r;
  endfunction

  assign {bus.sysmap_arb_flg_y, bus.sysmap_arb_hit_y} = sysmap_lookup(bus.arb_sysmap_pa_y);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic flush);
    bus.req_vld          = req;
    bus.mmu_sysmap_flush = flush;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.req_vld          = v.req;
    bus.req_pa           = {v.pa2, v.pa1, v.pa0};
    bus.mmu_sysmap_flush = v.flush;
  endtask

  task automatic check_output(input vec_t v, input int n);
    check($sformatf("vec%0d gnt", n), 32'(bus.arb_gnt), 32'(v.gnt));
    check($sformatf("vec%0d resp_vld", n), 32'(bus.resp_vld), 32'(v.rv));
    if (v.rv) begin
      check($sformatf("vec%0d resp_id", n), 32'(bus.resp_id), 32'(v.rid));
      check($sformatf("vec%0d resp_flg", n), 32'(bus.resp_flg), 32'(v.rflg));
      check($sformatf("vec%0d resp_hit", n), 32'(bus.resp_hit), 32'(v.rhit));
      check($sformatf("vec%0d resp_miss", n), 32'(bus.resp_miss), 32'(v.rhit == 8'h00));
    end
    if (v.chk_pa) begin
      check($sformatf("vec%0d pa_y", n), 32'(bus.arb_sysmap_pa_y), 32'(v.pa_y));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " resp_vld"}, 32'(bus.resp_vld), 32'd0);
    check({tag, " gnt"}, 32'(bus.arb_gnt), 32'd0);
    check({tag, " busy"}, 32'(bus.arb_busy), 32'd0);
    check({tag, " pa_y"}, 32'(bus.arb_sysmap_pa_y), 32'd0);
    check({tag, " resp_id"}, 32'(bus.resp_id), 32'd0);
    check({tag, " resp_flg"}, 32'(bus.resp_flg), 32'd0);
    check({tag, " resp_hit"}, 32'(bus.resp_hit), 32'd0);
    check({tag, " resp_miss"}, 32'(bus.resp_miss), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    lookup_t     q[$];
    logic        pend[NREQ];
    logic [27:0] ppa[NREQ];
    int          m_ptr;

    // Round robin, single request, miss and flush, one row per cycle from reset.
    vecs.push_back('{3'b111, PA_R1, PA_R2, PA_R3, 1'b0, 3'b001, 1'b0, 2'd0, 5'h00, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b111, PA_R1, PA_R2, PA_R3, 1'b0, 3'b010, 1'b0, 2'd0, 5'h00, 8'h00, 1'b1, PA_R1});
    vecs.push_back('{3'b111, PA_R1, PA_R2, PA_R3, 1'b0, 3'b100, 1'b1, 2'd0, 5'h09, 8'h02, 1'b1, PA_R2});
    vecs.push_back('{3'b111, PA_R1, PA_R2, PA_R3, 1'b0, 3'b001, 1'b1, 2'd1, 5'h0A, 8'h04, 1'b1, PA_R3});
    vecs.push_back('{3'b111, PA_R1, PA_R2, PA_R3, 1'b0, 3'b010, 1'b1, 2'd2, 5'h0B, 8'h08, 1'b1, PA_R1});
    vecs.push_back('{3'b111, PA_R1, PA_R2, PA_R3, 1'b0, 3'b100, 1'b1, 2'd0, 5'h09, 8'h02, 1'b1, PA_R2});
    vecs.push_back('{3'b000, PA_R1, PA_R2, PA_R3, 1'b0, 3'b000, 1'b1, 2'd1, 5'h0A, 8'h04, 1'b1, PA_R3});
    vecs.push_back('{3'b000, PA_R1, PA_R2, PA_R3, 1'b0, 3'b000, 1'b1, 2'd2, 5'h0B, 8'h08, 1'b0, 28'h0});
    vecs.push_back('{3'b010, PA_R1, PA_A,  PA_R3, 1'b0, 3'b010, 1'b0, 2'd0, 5'h00, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b000, PA_R1, PA_A,  PA_R3, 1'b0, 3'b000, 1'b0, 2'd0, 5'h00, 8'h00, 1'b1, PA_A});
    vecs.push_back('{3'b000, PA_R1, PA_A,  PA_R3, 1'b0, 3'b000, 1'b1, 2'd1, 5'h08, 8'h01, 1'b0, 28'h0});
    vecs.push_back('{3'b001, PA_MISS, PA_A, PA_R3, 1'b0, 3'b001, 1'b0, 2'd0, 5'h00, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b000, PA_MISS, PA_A, PA_R3, 1'b0, 3'b000, 1'b0, 2'd0, 5'h00, 8'h00, 1'b1, PA_MISS});
    vecs.push_back('{3'b000, PA_MISS, PA_A, PA_R3, 1'b0, 3'b000, 1'b1, 2'd0, 5'h13, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b010, PA_R3, PA_R1, PA_R2, 1'b0, 3'b010, 1'b0, 2'd0, 5'h00, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b100, PA_R3, PA_R1, PA_R2, 1'b0, 3'b100, 1'b0, 2'd0, 5'h00, 8'h00, 1'b1, PA_R1});
    vecs.push_back('{3'b001, PA_R3, PA_R1, PA_R2, 1'b1, 3'b000, 1'b0, 2'd0, 5'h00, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b001, PA_R3, PA_R1, PA_R2, 1'b0, 3'b001, 1'b0, 2'd0, 5'h00, 8'h00, 1'b0, 28'h0});
    vecs.push_back('{3'b000, PA_R3, PA_R1, PA_R2, 1'b0, 3'b000, 1'b0, 2'd0, 5'h00, 8'h00, 1'b1, PA_R3});
    vecs.push_back('{3'b000, PA_R3, PA_R1, PA_R2, 1'b0, 3'b000, 1'b1, 2'd0, 5'h0B, 8'h08, 1'b0, 28'h0});

    rst = 1'b1;
    bus.req_vld = '0;
    bus.req_pa = '0;
    bus.mmu_sysmap_flush = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;

    foreach (vecs[n]) begin
      apply_stimulus(vecs[n]);
      #1;
      check_output(vecs[n], n);
      tick();
    end

    // Requester 2 withdraws while requester 1 is being served; pointer stays at 1.
    bus.req_pa = {PA_R2, PA_R1, PA_R3};
    drive(3'b110, 1'b0); #1;
    check("wd0 gnt", 32'(bus.arb_gnt), 32'b010);
    tick();
    drive(3'b000, 1'b0); #1;
    check("wd1 gnt", 32'(bus.arb_gnt), 32'b000);
    tick();
    drive(3'b011, 1'b0); #1;
    check("wd2 gnt", 32'(bus.arb_gnt), 32'b001);
    check("wd2 resp_vld", 32'(bus.resp_vld), 32'd1);
    check("wd2 resp_id", 32'(bus.resp_id), 32'd1);
    tick();
    drive(3'b000, 1'b0); #1;
    check("wd3 resp_vld", 32'(bus.resp_vld), 32'd0);
    tick();
    #1;
    check("wd4 resp_vld", 32'(bus.resp_vld), 32'd1);
    check("wd4 resp_id", 32'(bus.resp_id), 32'd0);
    tick();

    // Async reset with both stages full; afterwards requester 0 must win first.
    drive(3'b011, 1'b0); #1;
    check("rs0 gnt", 32'(bus.arb_gnt), 32'b010);
    tick();
    #1;
    check("rs1 gnt", 32'(bus.arb_gnt), 32'b001);
    tick();
    #1;
    check("rs2 busy", 32'(bus.arb_busy), 32'd1);
    check("rs2 resp_vld", 32'(bus.resp_vld), 32'd1);
    rst = 1'b1;
    #1;
    check_idle("midreset");
    tick();
    rst = 1'b0;
    #1;
    check("rs3 gnt", 32'(bus.arb_gnt), 32'b001);
    tick();
    drive(3'b000, 1'b0); #1;
    check("rs4 resp_vld", 32'(bus.resp_vld), 32'd0);
    tick();
    #1;
    check("rs5 resp_vld", 32'(bus.resp_vld), 32'd1);
    check("rs5 resp_id", 32'(bus.resp_id), 32'd0);
    tick();

    // Random traffic against a queue of in-flight lookups keyed by due cycle.
    rst = 1'b1;
    drive(3'b000, 1'b0);
    tick();
    rst = 1'b0;
    m_ptr = NREQ - 1;
    q.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      ppa[i]  = '0;
    end

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        flush;
      int          gid;
      logic [2:0]  exp_gnt;
      logic        exp_rv;
      logic        exp_busy;
      lookup_t     due_now;
      sysmap_rsp_t exp_rsp;

      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          ppa[i]  = 28'($urandom);
        end
        bus.req_vld[i] = pend[i];
        bus.req_pa[i*PAW +: PAW] = ppa[i];
      end
      bus.mmu_sysmap_flush = flush;
      #1;

      gid = -1;
      if (!flush) begin
        for (int d = 1; d <= NREQ; d++) begin
          if (gid < 0 && pend[(m_ptr + d) % NREQ]) begin
            gid = (m_ptr + d) % NREQ;
          end
        end
      end
      exp_gnt = (gid >= 0) ? 3'(1 << gid) : 3'b000;

      exp_rv   = 1'b0;
      exp_busy = 1'b0;
      due_now  = '{0, 0, '0};
      foreach (q[k]) begin
        exp_busy = 1'b1;
        if (q[k].due == cyc) begin
          exp_rv  = !flush;
          due_now = q[k];
        end else begin
          check("rnd pa_y", 32'(bus.arb_sysmap_pa_y), 32'(q[k].pa));
        end
      end

      check("rnd gnt", 32'(bus.arb_gnt), 32'(exp_gnt));
      check("rnd resp_vld", 32'(bus.resp_vld), 32'(exp_rv));
      check("rnd busy", 32'(bus.arb_busy), 32'(exp_busy));
      if (exp_rv) begin
        exp_rsp = sysmap_lookup(due_now.pa);
        check("rnd resp_id", 32'(bus.resp_id), 32'(due_now.id));
        check("rnd resp_flg", 32'(bus.resp_flg), 32'(exp_rsp.flg));
        check("rnd resp_hit", 32'(bus.resp_hit), 32'(exp_rsp.hit));
        check("rnd resp_miss", 32'(bus.resp_miss), 32'(exp_rsp.hit == 8'h00));
      end

      if (flush) begin
        q.delete();
      end else begin
        for (int k = q.size() - 1; k >= 0; k--) begin
          if (q[k].due == cyc) q.delete(k);
        end
      end
      if (gid >= 0) begin
        q.push_back('{cyc + 2, gid, ppa[gid]});
        m_ptr     = gid;
        pend[gid] = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_mmu_sysmap_arb.md
Name: ct_mmu_sysmap_arb

Overview:
- Shares the single combinational sysmap attribute lookup between several MMU requesters, for example ITLB refill, DTLB/JTLB refill and the page-table walker.
- Round-robin arbitration with one grant per cycle.
- The lookup PA is registered before the sysmap compare, and the returned flag/hit vector is registered again.
- Fixed 2-cycle, fully pipelined lookup service with flush kill. Sits in the MMU top between the requesters and the sysmap instance.

Parameters:
- NREQ, 3, number of requesters (2..8)
- PA_WIDTH, 28, physical page number width (PA[39:12])
- FLG_WIDTH, 5, sysmap attribute flag width
- HIT_WIDTH, 8, number of sysmap regions
- ID_WIDTH, $clog2(NREQ), requester id width

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  asynchronous, active-high reset
- req_vld  in  NREQ  per-requester lookup request; held until granted
- req_pa  in  NREQ*PA_WIDTH  packed per-requester PPN; requester i uses slice i
- arb_gnt  out  NREQ  one-hot grant, combinational in the request cycle
- resp_vld  out  1  lookup result valid (single-cycle pulse)
- resp_id  out  ID_WIDTH  requester owning the result
- resp_flg  out  FLG_WIDTH  sysmap flags
- resp_hit  out  HIT_WIDTH  region hit vector
- resp_miss  out  1  resp_hit == 0 (flags carry the sysmap default)
- arb_sysmap_pa_y  out  PA_WIDTH  registered PPN driven to sysmap
- sysmap_arb_flg_y  in  FLG_WIDTH  sysmap flag result (combinational from arb_sysmap_pa_y)
- sysmap_arb_hit_y  in  HIT_WIDTH  sysmap hit result
- mmu_sysmap_flush  in  1  kill all in-flight lookups (sysmap reconfig / pipeline flush)
- arb_busy  out  1  s1_vld | s2_vld; clock-gate enable for the lookup path

Behaviour:
- Reset (async, cpurst=1) clears all state:
  - s1_vld, s2_vld = 0; rr_ptr = NREQ-1, so requester 0 wins first.
  - s1/s2 data = 0; arb_gnt = 0; resp_vld = 0; resp_id/flg/hit = 0; resp_miss = 1; arb_sysmap_pa_y = 0; arb_busy = 0.
- Reset mid-lookup drops the lookup; no response is produced.
- Arbitration (cycle T):
  - Grant the first asserted req_vld scanning from rr_ptr+1 upward, modulo NREQ.
  - arb_gnt is one-hot or zero.
  - On a grant, rr_ptr updates to the granted index at the edge; with no grant, rr_ptr holds.
  - A requester not granted keeps req_vld and req_pa stable.
  - Deasserting req_vld before grant is legal (request withdrawn).
- Stage 1 (edge ending T): s1_vld = granted & ~flush; s1_id = granted index; s1_pa = granted PPN. arb_sysmap_pa_y = s1_pa.
- Stage 2 (edge ending T+1): s2_vld = s1_vld & ~flush; s2_flg/s2_hit sample sysmap_arb_flg_y/hit_y; s2_id = s1_id.
- Response (cycle T+2):
  - resp_vld = s2_vld & ~mmu_sysmap_flush.
  - resp_flg, resp_hit and resp_id come from s2.
  - Grant-to-response latency is exactly 2 cycles.
  - Throughput is one lookup per cycle, back-to-back, including the same requester twice.
- No backpressure: requesters must always accept resp_vld.
- Flush, asserted in cycle F:
  - arb_gnt = 0 in F and rr_ptr holds.
  - resp_vld is forced 0 in F.
  - s1_vld and s2_vld clear at the edge ending F, so lookups granted in F-2..F never respond.
  - Requesters must reissue after flush drops.
- Flush coincident with reset: reset dominates.
- Flags are passed through unmodified, including the sysmap default 5'b10011 on miss. The hit vector is assumed one-hot/zero; no multi-hit check.
- Width rules: all PPN compares and muxes use PA_WIDTH bits; the requester index wraps at NREQ, not 2^ID_WIDTH.

Decomposition:
- Package ct_mmu_sysmap_pkg holds:
  - constants SYSMAP_PA_WIDTH=28, SYSMAP_FLG_WIDTH=5, SYSMAP_HIT_WIDTH=8, SYSMAP_FLG_DFLT=5'b10011;
  - typedef sysmap_rsp_t {flg, hit}.
- One sub-module, ct_mmu_sysmap_rr_arb: parameterised NREQ round-robin arbiter with a one-hot grant and pointer register, reusable elsewhere in the MMU.
- Pipeline registers and flush logic stay in the top module.

Test Plan:
- Reset then a single request: req_vld=3'b010, PPN 0x0001234. Require arb_gnt=3'b010 in the same cycle, arb_sysmap_pa_y=0x0001234 at T+1, and resp_vld with resp_id=1 at T+2 carrying the sysmap flg/hit seen at T+1.
- All three requesters held asserted for 6 cycles: grants 001,010,100,001,010,100 and responses ids 0,1,2,0,1,2 on consecutive cycles starting at T+2.
- Miss: PPN outside all regions gives resp_hit=0, resp_miss=1, resp_flg=5'b10011.
- Flush: grants in cycles 0,1,2 with flush=1 in cycle 2. Require arb_gnt=0 in cycle 2 and no resp_vld in cycles 2,3,4. A request in cycle 3 responds in cycle 5.
- Async reset asserted mid-stream while s1 and s2 are valid: all outputs drop immediately; after release, the first grant goes to requester 0.
- Withdrawn request: requester 2 drops req_vld before grant. Require no grant or response for id 2, and rr_ptr unaffected.
